// File: rtl/cp0_pkg.sv
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants for coprocessor 0: register numbers,
//               exception codes and SR/Cause field positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_OV  = 5'd12
    } exc_code_e;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int NUM_INT      = 6;

endpackage

`default_nettype wire

// File: rtl/int_sync.sv
// ============================================================================
// Module      : int_sync
// Description : Parameterised-width two-flop synchroniser, active-low
//               synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/cp0_unit.sv
// ============================================================================
// Module      : cp0_unit
// Description : MIPS coprocessor 0 - SR/Cause/EPC/PRId, mtc0/mfc0/eret,
//               interrupt synchronisation and exception request handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_VEC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL    = 32'h0000_0131
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  sel,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    input  logic        eret,
    input  logic        ovf,
    input  logic        boundary,
    input  logic [31:0] pc_cur,
    input  logic [31:0] pc_next,
    input  logic [5:0]  hw_int,
    output logic        exc_req,
    input  logic        exc_ack,
    output logic [31:0] exc_pc
);

    logic [NUM_INT-1:0] ip;
    logic [NUM_INT-1:0] im_q, im_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    exc_code_e          exc_code_q, exc_code_d;
    logic [31:0]        epc_q, epc_d;
    logic               exc_req_q, exc_req_d;
    logic               int_take, ovf_take;

    int_sync #(
        .WIDTH (NUM_INT)
    ) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (hw_int),
        .q   (ip)
    );

    // eret suppresses any entry in the same cycle; it only occurs with EXL=1
    // in a legal sequence, so this merely resolves the illegal overlap.
    always_comb begin
        ovf_take = ovf & ~exl_q & ~exc_req_q & ~eret;
        int_take = boundary & ie_q & ~exl_q & (|(ip & im_q)) & ~exc_req_q & ~eret;

        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        exc_req_d  = exc_req_q;

        if (we && sel == CP0_SR) begin
            im_d  = wdata[SR_IM_LO +: NUM_INT];
            exl_d = wdata[SR_EXL];
            ie_d  = wdata[SR_IE];
        end
        if (we && sel == CP0_EPC) begin
            epc_d = wdata;
        end
        if (eret) begin
            exl_d = 1'b0;
        end

        // Entry overrides any simultaneous mtc0 for EPC, EXL and ExcCode.
        if (ovf_take) begin
            epc_d      = pc_cur;
            exc_code_d = EXC_OV;
            exl_d      = 1'b1;
            exc_req_d  = 1'b1;
        end else if (int_take) begin
            epc_d      = pc_next;
            exc_code_d = EXC_INT;
            exl_d      = 1'b1;
            exc_req_d  = 1'b1;
        end else if (exc_ack) begin
            exc_req_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            exc_code_q <= EXC_INT;
            epc_q      <= '0;
            exc_req_q  <= 1'b0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            exc_req_q  <= exc_req_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            CP0_SR: begin
                rdata[SR_IM_LO +: NUM_INT] = im_q;
                rdata[SR_EXL]              = exl_q;
                rdata[SR_IE]               = ie_q;
            end
            CP0_CAUSE: begin
                rdata[CAUSE_IP_LO +: NUM_INT] = ip;
                rdata[CAUSE_EXC_LO +: 5]      = exc_code_q;
            end
            CP0_EPC:  rdata = epc_q;
            CP0_PRID: rdata = PRID_VAL;
            default:  rdata = '0;
        endcase
    end

    assign exc_req = exc_req_q;
    assign exc_pc  = exc_req_q ? HANDLER_VEC : epc_q;

endmodule

`default_nettype wire
